meas_sequencer: RTL

Top-level measurement controller for the measurement datapath (DC remover, wave identifier, frequency counter, modulation-depth unit).
- Sequences one measurement run: settle, wait for a stable frequency, classify the waveform, optionally run modulation-depth measurement, then publish a coherent result snapshot.
- Publishes results to the display/UART side over a valid/ready handshake.
- Owns the ma_measure_enable gate and never lets it assert for a non-sine input.

---
 rtl/meas_sequencer.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/meas_sequencer.sv
// Measurement run sequencer: settle, frequency lock, classify, optional
// modulation-depth phase, then a held result snapshot on a valid/ready port.
module meas_sequencer #(
    parameter int SETTLE_TICKS  = 64,
    parameter int STABLE_TICKS  = 400,
    parameter int TIMEOUT_TICKS = 4000,
    parameter int MA_TICKS      = 1000,
    parameter int CNT_W         = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sample_en,
    input  logic        start,
    input  logic        continuous,
    input  logic        abort,
    input  logic        ma_cfg_en,
    input  logic [15:0] freq_in,
    input  logic        is_sine_in,
    input  logic [31:0] papr_in,
    input  logic [7:0]  ma_in,
    output logic        ma_measure_enable,
    output logic        busy,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [15:0] res_freq,
    output logic        res_is_sine,
    output logic [31:0] res_papr,
    output logic [7:0]  res_ma,
    output logic        res_timeout,
    output logic [2:0]  state_dbg
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_SETTLE   = 3'd1,
        S_FREQ     = 3'd2,
        S_CLASSIFY = 3'd3,
        S_MA_RUN   = 3'd4,
        S_REPORT   = 3'd5
    } state_t;

    localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(SETTLE_TICKS - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_TICKS - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_TICKS - 1);
    localparam logic [CNT_W-1:0] MA_LAST      = CNT_W'(MA_TICKS - 1);

    state_t           r_state;
    logic [CNT_W-1:0] r_settle_cnt;
    logic [CNT_W-1:0] r_stable_cnt;
    logic [CNT_W-1:0] r_timeout_cnt;
    logic [CNT_W-1:0] r_ma_cnt;
    logic [15:0]      r_freq_prev;
    logic             r_to_flag;
    logic [15:0]      r_snap_freq;
    logic             r_snap_sine;
    logic [31:0]      r_snap_papr;
    logic [7:0]       r_snap_ma;
    logic             r_snap_to;
    logic             r_ma_en;
    logic             r_res_valid;

    logic w_same;
    logic w_stable_done;
    logic w_to_done;
    logic w_ma_ok;

    assign w_same        = (freq_in == r_freq_prev);
    assign w_stable_done = w_same && (r_stable_cnt >= STABLE_LAST);
    assign w_to_done     = (r_timeout_cnt >= TIMEOUT_LAST);
    assign w_ma_ok       = is_sine_in & ma_cfg_en;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_settle_cnt  <= '0;
            r_stable_cnt  <= '0;
            r_timeout_cnt <= '0;
            r_ma_cnt      <= '0;
            r_freq_prev   <= '0;
            r_to_flag     <= 1'b0;
            r_snap_freq   <= '0;
            r_snap_sine   <= 1'b0;
            r_snap_papr   <= '0;
            r_snap_ma     <= '0;
            r_snap_to     <= 1'b0;
            r_ma_en       <= 1'b0;
            r_res_valid   <= 1'b0;
        end else if (abort) begin
            // Snapshot registers deliberately survive an abort
            r_state     <= S_IDLE;
            r_ma_en     <= 1'b0;
            r_res_valid <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state      <= S_SETTLE;
                        r_settle_cnt <= '0;
                    end
                end
                S_SETTLE: begin
                    if (sample_en) begin
                        if (r_settle_cnt >= SETTLE_LAST) begin
                            r_state       <= S_FREQ;
                            r_freq_prev   <= freq_in;
                            r_stable_cnt  <= '0;
                            r_timeout_cnt <= '0;
                            r_to_flag     <= 1'b0;
                        end else begin
                            r_settle_cnt <= r_settle_cnt + 1'b1;
                        end
                    end
                end
                S_FREQ: begin
                    if (sample_en) begin
                        r_timeout_cnt <= r_timeout_cnt + 1'b1;
                        if (w_same) begin
                            r_stable_cnt <= r_stable_cnt + 1'b1;
                        end else begin
                            r_stable_cnt <= '0;
                            r_freq_prev  <= freq_in;
                        end
                        // A stable lock on the timeout tick is still a lock
                        if (w_stable_done) begin
                            r_state   <= S_CLASSIFY;
                            r_to_flag <= 1'b0;
                        end else if (w_to_done) begin
                            r_state   <= S_CLASSIFY;
                            r_to_flag <= 1'b1;
                        end
                    end
                end
                S_CLASSIFY: begin
                    r_snap_freq <= r_freq_prev;
                    r_snap_sine <= is_sine_in;
                    r_snap_papr <= papr_in;
                    r_snap_to   <= r_to_flag;
                    if (w_ma_ok) begin
                        r_state  <= S_MA_RUN;
                        r_ma_en  <= 1'b1;
                        r_ma_cnt <= '0;
                    end else begin
                        r_state     <= S_REPORT;
                        r_snap_ma   <= '0;
                        r_res_valid <= 1'b1;
                    end
                end
                S_MA_RUN: begin
                    if (!w_ma_ok) begin
                        r_state     <= S_REPORT;
                        r_snap_ma   <= '0;
                        r_ma_en     <= 1'b0;
                        r_res_valid <= 1'b1;
                    end else if (sample_en) begin
                        if (r_ma_cnt >= MA_LAST) begin
                            r_state     <= S_REPORT;
                            r_snap_ma   <= ma_in;
                            r_ma_en     <= 1'b0;
                            r_res_valid <= 1'b1;
                        end else begin
                            r_ma_cnt <= r_ma_cnt + 1'b1;
                        end
                    end
                end
                S_REPORT: begin
                    if (r_res_valid && res_ready) begin
                        r_res_valid <= 1'b0;
                        if (continuous) begin
                            r_state       <= S_FREQ;
                            r_freq_prev   <= freq_in;
                            r_stable_cnt  <= '0;
                            r_timeout_cnt <= '0;
                            r_to_flag     <= 1'b0;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign ma_measure_enable = r_ma_en;
    assign busy              = (r_state != S_IDLE);
    assign res_valid         = r_res_valid;
    assign res_freq          = r_snap_freq;
    assign res_is_sine       = r_snap_sine;
    assign res_papr          = r_snap_papr;
    assign res_ma            = r_snap_ma;
    assign res_timeout       = r_snap_to;
    assign state_dbg         = r_state;

endmodule
